// File: rtl/vector_pkg.sv
// vector_pkg: shared vector display-list format constants.
// Used by the list writer and the vector renderer.
package vector_pkg;

  localparam logic [1:0] VEC_OP_BEGIN = 2'd0;
  localparam logic [1:0] VEC_OP_POINT = 2'd1;
  localparam logic [1:0] VEC_OP_END   = 2'd2;
  localparam logic [1:0] VEC_OP_CLEAR = 2'd3;

  localparam int VEC_COLOUR_MSB = 7;
  localparam int VEC_COLOUR_LSB = 4;
  localparam int VEC_INTENS_MSB = 3;
  localparam int VEC_INTENS_LSB = 0;

  localparam int VEC_MAX_POINTS = 16;
  localparam int VEC_HDR_BYTES  = 2;
  localparam int VEC_PT_BYTES   = 2;

  typedef struct packed {
    logic [7:0] y;
    logic [7:0] x;
  } vec_point_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BEG_LEN,
    ST_BEG_ATTR,
    ST_PT_X,
    ST_PT_Y,
    ST_END_TERM,
    ST_END_LEN,
    ST_CLR
  } vw_state_e;

  function automatic logic [7:0] vec_attr(
    input logic [3:0] colour,
    input logic [3:0] intensity
  );
    return {colour, intensity};
  endfunction

endpackage

// File: rtl/vector_list_writer.sv
// vector_list_writer: encodes BEGIN/POINT/END/CLEAR into vector RAM bytes.
// Define VECTOR_LIST_WRITER_DEDUP_EN to drop repeated points silently.
module vector_list_writer
  import vector_pkg::*;
#(
  parameter int VECTOR_RAM_WIDTH = 9,
  parameter int MAX_POINTS       = VEC_MAX_POINTS
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [1:0]                  cmd_op,
  input  logic [15:0]                 cmd_data,
  output logic [VECTOR_RAM_WIDTH-1:0] ram_addr,
  output logic [7:0]                  ram_data,
  output logic                        ram_we,
  output logic [7:0]                  line_count,
  output logic                        overflow,
  output logic                        seq_err
);

  localparam int AW = VECTOR_RAM_WIDTH;
  localparam int PW = AW + 1;
  localparam int CW = $clog2(MAX_POINTS + 1);
  localparam logic [PW-1:0] DEPTH = PW'(1) << AW;
  localparam logic [PW:0] BEG_NEED =
    (PW+1)'(VEC_HDR_BYTES + 2 * VEC_PT_BYTES + 1);
  localparam logic [PW:0] PT_NEED = (PW+1)'(VEC_PT_BYTES + 1);

  vw_state_e     state;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] line_start;
  logic [PW-1:0] wr_ptr_p1;
  logic [PW-1:0] wr_ptr_p2;
  logic [CW-1:0] pt_cnt;
  logic          line_open;
  logic          pend_beg;
  logic [7:0]    attr_q;
  logic [7:0]    y_q;
  logic [7:0]    cmd_attr;
  vec_point_t    pt_in;
  logic          beg_fits;
  logic          pt_fits;
  logic          pt_full;
  logic          is_dup;
  logic          pt_go;
  logic          acc_beg;
  logic          acc_pt;
  logic          acc_end;
  logic          acc_clr;

  assign pt_in     = cmd_data;
  assign cmd_attr  = vec_attr(cmd_data[VEC_COLOUR_MSB:VEC_COLOUR_LSB],
                              cmd_data[VEC_INTENS_MSB:VEC_INTENS_LSB]);
  assign wr_ptr_p1 = wr_ptr + PW'(1);
  assign wr_ptr_p2 = wr_ptr + PW'(2);
  // one spare bit so wr_ptr near DEPTH never wraps in the compare
  assign beg_fits  = ({1'b0, wr_ptr} + BEG_NEED) <= {1'b0, DEPTH};
  assign pt_fits   = ({1'b0, wr_ptr} + PT_NEED) <= {1'b0, DEPTH};
  assign pt_full   = pt_cnt == CW'(MAX_POINTS);

  assign acc_beg = cmd_valid && cmd_ready && cmd_op == VEC_OP_BEGIN;
  assign acc_pt  = cmd_valid && cmd_ready && cmd_op == VEC_OP_POINT;
  assign acc_end = cmd_valid && cmd_ready && cmd_op == VEC_OP_END;
  assign acc_clr = cmd_valid && cmd_ready && cmd_op == VEC_OP_CLEAR;

`ifdef VECTOR_LIST_WRITER_DEDUP_EN
  logic [15:0] last_pt;

  assign is_dup = (pt_cnt != '0) && (cmd_data == last_pt);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_pt <= '0;
    end else if (pt_go) begin
      last_pt <= cmd_data;
    end
  end
`else
  assign is_dup = 1'b0;
`endif

  assign pt_go = acc_pt && line_open && !is_dup && !pt_full && pt_fits;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      cmd_ready  <= 1'b1;
      wr_ptr     <= '0;
      line_start <= '0;
      pt_cnt     <= '0;
      line_open  <= 1'b0;
      pend_beg   <= 1'b0;
      attr_q     <= '0;
      y_q        <= '0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_data   <= '0;
      line_count <= '0;
      overflow   <= 1'b0;
      seq_err    <= 1'b0;
    end else begin
      ram_we <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          unique case (1'b1)
            acc_clr: begin
              ram_we     <= 1'b1;
              ram_addr   <= '0;
              ram_data   <= '0;
              wr_ptr     <= '0;
              pt_cnt     <= '0;
              line_open  <= 1'b0;
              pend_beg   <= 1'b0;
              line_count <= '0;
              overflow   <= 1'b0;
              seq_err    <= 1'b0;
              cmd_ready  <= 1'b0;
              state      <= ST_CLR;
            end
            acc_beg: begin
              attr_q <= cmd_attr;
              if (line_open) begin
                // drop the open line, then retry this BEGIN
                seq_err   <= 1'b1;
                pend_beg  <= 1'b1;
                ram_we    <= 1'b1;
                ram_addr  <= line_start[AW-1:0];
                ram_data  <= '0;
                wr_ptr    <= line_start;
                line_open <= 1'b0;
                cmd_ready <= 1'b0;
                state     <= ST_END_LEN;
              end else if (beg_fits) begin
                ram_we    <= 1'b1;
                ram_addr  <= wr_ptr[AW-1:0];
                ram_data  <= '0;
                cmd_ready <= 1'b0;
                state     <= ST_BEG_LEN;
              end else begin
                overflow <= 1'b1;
              end
            end
            acc_pt: begin
              y_q <= pt_in.y;
              if (!line_open) begin
                seq_err <= 1'b1;
              end else if (pt_go) begin
                ram_we    <= 1'b1;
                ram_addr  <= wr_ptr[AW-1:0];
                ram_data  <= pt_in.x;
                cmd_ready <= 1'b0;
                state     <= ST_PT_X;
              end else if (!is_dup) begin
                overflow <= 1'b1;
              end
            end
            acc_end: begin
              if (!line_open) begin
                seq_err <= 1'b1;
              end else if (pt_cnt >= CW'(2)) begin
                ram_we    <= 1'b1;
                ram_addr  <= wr_ptr[AW-1:0];
                ram_data  <= '0;
                cmd_ready <= 1'b0;
                state     <= ST_END_TERM;
              end else begin
                ram_we    <= 1'b1;
                ram_addr  <= line_start[AW-1:0];
                ram_data  <= '0;
                wr_ptr    <= line_start;
                line_open <= 1'b0;
                cmd_ready <= 1'b0;
                state     <= ST_END_LEN;
              end
            end
            default: ;
          endcase
        end
        ST_BEG_LEN: begin
          ram_we     <= 1'b1;
          ram_addr   <= wr_ptr_p1[AW-1:0];
          ram_data   <= attr_q;
          line_start <= wr_ptr;
          wr_ptr     <= wr_ptr_p2;
          pt_cnt     <= '0;
          line_open  <= 1'b1;
          state      <= ST_BEG_ATTR;
        end
        ST_BEG_ATTR: begin
          cmd_ready <= 1'b1;
          state     <= ST_IDLE;
        end
        ST_PT_X: begin
          ram_we   <= 1'b1;
          ram_addr <= wr_ptr_p1[AW-1:0];
          ram_data <= y_q;
          wr_ptr   <= wr_ptr_p2;
          pt_cnt   <= pt_cnt + CW'(1);
          state    <= ST_PT_Y;
        end
        ST_PT_Y: begin
          cmd_ready <= 1'b1;
          state     <= ST_IDLE;
        end
        ST_END_TERM: begin
          // length byte goes last so the list stays terminated
          ram_we    <= 1'b1;
          ram_addr  <= line_start[AW-1:0];
          ram_data  <= 8'(pt_cnt - CW'(1));
          line_open <= 1'b0;
          if (line_count != 8'hFF) begin
            line_count <= line_count + 8'd1;
          end
          state <= ST_END_LEN;
        end
        ST_END_LEN: begin
          if (pend_beg) begin
            pend_beg <= 1'b0;
            if (beg_fits) begin
              ram_we   <= 1'b1;
              ram_addr <= wr_ptr[AW-1:0];
              ram_data <= '0;
              state    <= ST_BEG_LEN;
            end else begin
              overflow  <= 1'b1;
              cmd_ready <= 1'b1;
              state     <= ST_IDLE;
            end
          end else begin
            cmd_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        ST_CLR: begin
          cmd_ready <= 1'b1;
          state     <= ST_IDLE;
        end
        default: begin
          cmd_ready <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vector_list_writer.sv
// tb_vector_list_writer: directed vector table plus corner sequences.
// Second instance with a 16-byte RAM covers BEGIN capacity drop.
module tb_vector_list_writer;
  import vector_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        s_valid = 1'b0;
  logic [1:0]  cmd_op = 2'd0;
  logic [15:0] cmd_data = 16'h0;

  logic        cmd_ready, ram_we, overflow, seq_err;
  logic [8:0]  ram_addr;
  logic [7:0]  ram_data, line_count;

  logic        s_ready, s_we, s_overflow, s_seq_err;
  logic [3:0]  s_addr;
  logic [7:0]  s_data, s_line_count;

  vector_list_writer #(.VECTOR_RAM_WIDTH(9)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we),
    .line_count(line_count), .overflow(overflow), .seq_err(seq_err)
  );

  vector_list_writer #(.VECTOR_RAM_WIDTH(4)) dut_s (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(s_valid), .cmd_ready(s_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data),
    .ram_addr(s_addr), .ram_data(s_data), .ram_we(s_we),
    .line_count(s_line_count), .overflow(s_overflow), .seq_err(s_seq_err)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:511];
  int wc_m = 0, wc_s = 0;
  int la_m = 0, ld_m = 0, la_s = 0, ld_s = 0;

  always @(negedge clk) begin
    if (ram_we) begin
      mem[ram_addr] = ram_data;
      wc_m++;
      la_m = int'(ram_addr);
      ld_m = int'(ram_data);
    end
    if (s_we) begin
      wc_s++;
      la_s = int'(s_addr);
      ld_s = int'(s_data);
    end
  end

  int vecs = 0;
  int miss = 0;

  task automatic chk(input string name, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      miss++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic bit rdy(input bit sel);
    return sel ? s_ready : cmd_ready;
  endfunction

  task automatic issue(input bit sel, input logic [1:0] op,
                       input logic [15:0] d, output int lat, output int nw);
    int n;
    @(negedge clk);
    n = 0;
    while (!rdy(sel) && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!rdy(sel)) begin
      vecs++;
      miss++;
      $display("FAIL ready_wait: ready low after %0d cycles", n);
    end
    cmd_op = op;
    cmd_data = d;
    if (sel) s_valid = 1'b1;
    else cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    s_valid = 1'b0;
    wc_m = 0;
    wc_s = 0;
    lat = 0;
    while (!rdy(sel) && lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
    end
    nw = sel ? wc_s : wc_m;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [15:0] d;
    int          lat;
    int          la;
    int          ld;
    int          lc;
    int          ov;
    int          se;
  } vec_t;

  vec_t tbl [18];

  initial begin
    int lat, nw;
    tbl[0]  = '{VEC_OP_CLEAR, 16'h0000, 1, 0,  8'h00, 0, 0, 0};
    tbl[1]  = '{VEC_OP_BEGIN, 16'h003F, 2, 1,  8'h3F, 0, 0, 0};
    tbl[2]  = '{VEC_OP_POINT, 16'h140A, 2, 3,  8'h14, 0, 0, 0};
    tbl[3]  = '{VEC_OP_POINT, 16'h1432, 2, 5,  8'h14, 0, 0, 0};
    tbl[4]  = '{VEC_OP_POINT, 16'h5032, 2, 7,  8'h50, 0, 0, 0};
    tbl[5]  = '{VEC_OP_END,   16'h0000, 2, 0,  8'h02, 1, 0, 0};
    tbl[6]  = '{VEC_OP_BEGIN, 16'h0011, 2, 9,  8'h11, 1, 0, 0};
    tbl[7]  = '{VEC_OP_POINT, 16'h0000, 2, 11, 8'h00, 1, 0, 0};
    tbl[8]  = '{VEC_OP_POINT, 16'hFFFF, 2, 13, 8'hFF, 1, 0, 0};
    tbl[9]  = '{VEC_OP_END,   16'h0000, 2, 8,  8'h01, 2, 0, 0};
    tbl[10] = '{VEC_OP_POINT, 16'h0101, 0, 0,  8'h00, 2, 0, 1};
    tbl[11] = '{VEC_OP_END,   16'h0000, 0, 0,  8'h00, 2, 0, 1};
    tbl[12] = '{VEC_OP_BEGIN, 16'h0022, 2, 15, 8'h22, 2, 0, 1};
    tbl[13] = '{VEC_OP_POINT, 16'h0505, 2, 17, 8'h05, 2, 0, 1};
    tbl[14] = '{VEC_OP_END,   16'h0000, 1, 14, 8'h00, 2, 0, 1};
    tbl[15] = '{VEC_OP_BEGIN, 16'h0033, 2, 15, 8'h33, 2, 0, 1};
    tbl[16] = '{VEC_OP_END,   16'h0000, 1, 14, 8'h00, 2, 0, 1};
    tbl[17] = '{VEC_OP_CLEAR, 16'h0000, 1, 0,  8'h00, 0, 0, 0};

    #12;
    chk("rst_ready", int'(cmd_ready), 1);
    chk("rst_we", int'(ram_we), 0);
    chk("rst_addr", int'(ram_addr), 0);
    chk("rst_data", int'(ram_data), 0);
    chk("rst_lc", int'(line_count), 0);
    chk("rst_ov", int'(overflow), 0);
    chk("rst_se", int'(seq_err), 0);
    chk("rst_s_ready", int'(s_ready), 1);
    @(negedge clk);
    reset_n = 1'b1;

    // small RAM: one 4-point line leaves wr_ptr=10, next BEGIN cannot fit
    issue(1'b1, VEC_OP_CLEAR, 16'h0, lat, nw);
    chk("s_clr_lat", lat, 1);
    issue(1'b1, VEC_OP_BEGIN, 16'h0001, lat, nw);
    chk("s_beg_lat", lat, 2);
    for (int i = 1; i <= 4; i++) begin
      issue(1'b1, VEC_OP_POINT, 16'(i * 257), lat, nw);
      chk("s_pt_lat", lat, 2);
    end
    issue(1'b1, VEC_OP_END, 16'h0, lat, nw);
    chk("s_end_lat", lat, 2);
    chk("s_end_addr", la_s, 0);
    chk("s_end_len", ld_s, 3);
    chk("s_lc", int'(s_line_count), 1);
    chk("s_ov_before", int'(s_overflow), 0);
    issue(1'b1, VEC_OP_BEGIN, 16'h0002, lat, nw);
    chk("s_drop_lat", lat, 0);
    chk("s_drop_writes", nw, 0);
    chk("s_ov", int'(s_overflow), 1);

    for (int i = 0; i < 18; i++) begin
      issue(1'b0, tbl[i].op, tbl[i].d, lat, nw);
      chk($sformatf("v%0d_lat", i), lat, tbl[i].lat);
      chk($sformatf("v%0d_writes", i), nw, tbl[i].lat);
      if (tbl[i].lat > 0) begin
        chk($sformatf("v%0d_last_addr", i), la_m, tbl[i].la);
        chk($sformatf("v%0d_last_data", i), ld_m, tbl[i].ld);
      end
      chk($sformatf("v%0d_lc", i), int'(line_count), tbl[i].lc);
      chk($sformatf("v%0d_ov", i), int'(overflow), tbl[i].ov);
      chk($sformatf("v%0d_se", i), int'(seq_err), tbl[i].se);
    end

    begin
      logic [7:0] img [15];
      img = '{8'h00, 8'h3F, 8'h0A, 8'h14, 8'h32, 8'h14, 8'h32, 8'h50,
              8'h01, 8'h11, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00};
      for (int a = 0; a < 15; a++)
        chk($sformatf("ram[%0d]", a), int'(mem[a]), int'(img[a]));
      chk("ram[15]", int'(mem[15]), 8'h33);
    end

    // 17 points on one line: last is dropped, length byte 15
    issue(1'b0, VEC_OP_BEGIN, 16'h0044, lat, nw);
    for (int i = 0; i < 17; i++) begin
      issue(1'b0, VEC_OP_POINT, {8'(i + 100), 8'(i)}, lat, nw);
      chk($sformatf("p%0d_lat", i), lat, (i < 16) ? 2 : 0);
    end
    chk("p17_ov", int'(overflow), 1);
    issue(1'b0, VEC_OP_END, 16'h0, lat, nw);
    chk("p17_last_addr", la_m, 0);
    chk("p17_len", int'(mem[0]), 15);
    chk("p17_term", int'(mem[34]), 0);
    chk("p17_y15", int'(mem[33]), 115);
    chk("p17_lc", int'(line_count), 1);

    // BEGIN on an open line: discard, then begin at the same address
    issue(1'b0, VEC_OP_BEGIN, 16'h0055, lat, nw);
    issue(1'b0, VEC_OP_POINT, 16'h0707, lat, nw);
    chk("rebeg_se_before", int'(seq_err), 0);
    issue(1'b0, VEC_OP_BEGIN, 16'h0066, lat, nw);
    chk("rebeg_lat", lat, 3);
    chk("rebeg_writes", nw, 3);
    chk("rebeg_last_addr", la_m, 35);
    chk("rebeg_attr", int'(mem[35]), 8'h66);
    chk("rebeg_len", int'(mem[34]), 0);
    chk("rebeg_se", int'(seq_err), 1);
    issue(1'b0, VEC_OP_END, 16'h0, lat, nw);
    chk("rebeg_end_lat", lat, 1);
    chk("rebeg_lc", int'(line_count), 1);

    // reset while PT_X is writing
    issue(1'b0, VEC_OP_BEGIN, 16'h0077, lat, nw);
    @(negedge clk);
    cmd_op = VEC_OP_POINT;
    cmd_data = 16'h0909;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    chk("ptx_we", int'(ram_we), 1);
    chk("ptx_ready", int'(cmd_ready), 0);
    reset_n = 1'b0;
    #1;
    chk("arst_we", int'(ram_we), 0);
    chk("arst_ready", int'(cmd_ready), 1);
    chk("arst_lc", int'(line_count), 0);
    chk("arst_se", int'(seq_err), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
